farmer_player: RTL

FARMER_PLAYER -- requirements
Module: farmer_player

---
 rtl/farmer_player.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/farmer_player.sv
// Player for the farmer river-crossing game: resets the game, then replays the fixed 7-move solution.
// Optional FARMER_PLAYER_STEP_EN adds a `step` input that gates every ISSUE.
//
// state  | meaning
// IDLE   | waiting for start after reset
// GRST   | one-cycle game reset pulse
// ISSUE  | en pulse with the current move, I sampled
// SETTLE | post-move L/W sampled, next move chosen
// GAP    | idle spacing (and step wait) before the next ISSUE
// DONE   | game won, waiting for start
// FAIL   | sequence aborted, waiting for start
module farmer_player #(
  parameter int STEP_GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       W,
  input  logic       L,
  input  logic       I,
`ifdef FARMER_PLAYER_STEP_EN
  input  logic       step,
`endif
  output logic [1:0] M,
  output logic       en,
  output logic       grst,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] fail_code,
  output logic [2:0] move_cnt
);

  typedef enum logic [2:0] {IDLE, GRST, ISSUE, SETTLE, GAP, DONE, FAIL} state_t;

  localparam logic [15:0] GAP_LOAD = (STEP_GAP > 0) ? 16'(STEP_GAP - 1) : 16'd0;

  // GAP is entered before every ISSUE, the first included, whenever there is spacing or a step gate.
`ifdef FARMER_PLAYER_STEP_EN
  localparam bit USE_GAP = 1'b1;
  logic step_ok;
  assign step_ok = step;
`else
  localparam bit USE_GAP = (STEP_GAP > 0);
  logic step_ok;
  assign step_ok = 1'b1;
`endif

  state_t      state, state_nxt;
  logic [2:0]  index, index_nxt;
  logic [2:0]  cnt_nxt;
  logic [15:0] gap_cnt, gap_nxt;
  logic        done_nxt, fail_nxt;
  logic [1:0]  code_nxt;

  function automatic logic [1:0] seq_move(input logic [2:0] idx);
    case (idx)
      3'd0:    seq_move = 2'b10;
      3'd1:    seq_move = 2'b00;
      3'd2:    seq_move = 2'b01;
      3'd3:    seq_move = 2'b10;
      3'd4:    seq_move = 2'b11;
      3'd5:    seq_move = 2'b00;
      3'd6:    seq_move = 2'b10;
      default: seq_move = 2'b00;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    cnt_nxt   = move_cnt;
    gap_nxt   = gap_cnt;
    done_nxt  = done;
    fail_nxt  = fail;
    code_nxt  = fail_code;
    M         = 2'b00;
    en        = 1'b0;
    grst      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_nxt = GRST;
          index_nxt = 3'd0;
          cnt_nxt   = 3'd0;
          done_nxt  = 1'b0;
          fail_nxt  = 1'b0;
          code_nxt  = 2'b00;
        end
      end
      GRST: begin
        grst      = 1'b1;
        busy      = 1'b1;
        gap_nxt   = GAP_LOAD;
        state_nxt = USE_GAP ? GAP : ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        en   = 1'b1;
        M    = seq_move(index);
        if (I) begin
          state_nxt = FAIL;
          fail_nxt  = 1'b1;
          code_nxt  = 2'b01;
        end else begin
          state_nxt = SETTLE;
          cnt_nxt   = (move_cnt == 3'd7) ? 3'd7 : move_cnt + 3'd1;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (L) begin
          state_nxt = FAIL;
          fail_nxt  = 1'b1;
          code_nxt  = 2'b10;
        end else if (index == 3'd6) begin
          if (W) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = FAIL;
            fail_nxt  = 1'b1;
            code_nxt  = 2'b11;
          end
        end else begin
          index_nxt = index + 3'd1;
          gap_nxt   = GAP_LOAD;
          state_nxt = USE_GAP ? GAP : ISSUE;
        end
      end
      GAP: begin
        busy = 1'b1;
        if (gap_cnt != 16'd0) begin
          gap_nxt = gap_cnt - 16'd1;
        end else if (step_ok) begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      index     <= 3'd0;
      move_cnt  <= 3'd0;
      gap_cnt   <= 16'd0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'b00;
    end else begin
      state     <= state_nxt;
      index     <= index_nxt;
      move_cnt  <= cnt_nxt;
      gap_cnt   <= gap_nxt;
      done      <= done_nxt;
      fail      <= fail_nxt;
      fail_code <= code_nxt;
    end
  end

endmodule
